// File: rtl/setup_chk_pkg.sv
// setup_chk_pkg: shared types and constants for the setup-time sweep checker.
package setup_chk_pkg;

    localparam int CHK_OFFSET_W = 7;
    localparam int CHK_IDX_W    = 2;

    localparam int NBSLOPES_CK = 3;
    localparam int NBSLOPES_D  = 3;
    localparam int OFFSET_MAX  = 100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT
    } state_e;

    // One FIFO entry per completed (clk slope, d slope) point
    typedef struct packed {
        logic [CHK_IDX_W-1:0]    ck_idx;
        logic [CHK_IDX_W-1:0]    d_idx;
        logic [CHK_OFFSET_W-1:0] offset;
        logic                    found;
        logic                    nonmono;
    } res_t;

    // Slope indices beyond the 3x3 grid are flagged as protocol errors
    function automatic logic idx_ok(input logic [CHK_IDX_W-1:0] ck,
                                    input logic [CHK_IDX_W-1:0] d);
        return (ck <= CHK_IDX_W'(NBSLOPES_CK - 1)) &&
               (d  <= CHK_IDX_W'(NBSLOPES_D  - 1));
    endfunction

endpackage

// File: rtl/setup_chk_res_fifo.sv
// setup_chk_res_fifo: synchronous FIFO of result structs.
// A push while full only lands when a pop frees a slot in the same cycle.
module setup_chk_res_fifo
    import setup_chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  res_t push_data_i,
    input  logic pop_i,
    output res_t head_o,
    output logic empty_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);

    res_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rptr_q];

    // Occupancy next-state from the qualified push/pop pair
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers, occupancy and storage; reset empties and zeroes the head
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/setup_sweep_checker.sv
// setup_sweep_checker: classifies DFF setup-sweep trials and reports the
// minimum passing offset per slope point through a small result FIFO.
// Optional feature macro: SETUP_CHK_MONOTONIC_EN (fail tracking and
// non-monotonic detection; without it every pass updates the minimum).
module setup_sweep_checker
    import setup_chk_pkg::*;
#(
    parameter int OFFSET_W      = CHK_OFFSET_W,
    parameter int IDX_W         = CHK_IDX_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int RES_DEPTH     = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                trial_valid_i,
    output logic                trial_ready_o,
    input  logic [OFFSET_W-1:0] trial_offset_i,
    input  logic [IDX_W-1:0]    trial_ck_idx_i,
    input  logic [IDX_W-1:0]    trial_d_idx_i,
    input  logic                q_sample_i,
    input  logic                point_done_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [IDX_W-1:0]    res_ck_idx_o,
    output logic [IDX_W-1:0]    res_d_idx_o,
    output logic [OFFSET_W-1:0] res_offset_o,
    output logic                res_found_o,
    output logic                res_nonmono_o,
    output logic                ovf_o,
    output logic                proto_err_o
);

    localparam int CNT_W = 4;

    state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [IDX_W-1:0]    pt_ck_q, pt_ck_d, pt_d_q, pt_d_d;
    logic                pt_act_q, pt_act_d;
    logic [OFFSET_W-1:0] best_q, best_d;
    logic                found_q, found_d;
    logic                ovf_q, ovf_d;
    logic                proto_q, proto_d;
`ifdef SETUP_CHK_MONOTONIC_EN
    logic                fail_seen_q, fail_seen_d;
    logic                nonmono_q, nonmono_d;
`endif

    logic accept, do_sample, do_emit;
    logic fifo_full, fifo_empty, fifo_pop;
    res_t push_data, head;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: a trial takes priority over point_done in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trial_valid_i)     state_d = ST_SETTLE;
                else if (point_done_i) state_d = ST_EMIT;
            end
            ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_IDLE;
            ST_EMIT:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and per-state strobes
    always_comb begin
        trial_ready_o = (state_q == ST_IDLE);
        accept        = trial_ready_o & trial_valid_i;
        do_sample     = (state_q == ST_SAMPLE);
        do_emit       = (state_q == ST_EMIT);
    end

    // Datapath next state: trial latch, settle count, point accumulators, flags
    always_comb begin
        cnt_d    = cnt_q;
        off_d    = off_q;
        pt_ck_d  = pt_ck_q;
        pt_d_d   = pt_d_q;
        pt_act_d = pt_act_q;
        best_d   = best_q;
        found_d  = found_q;
        ovf_d    = ovf_q;
        proto_d  = proto_q;
`ifdef SETUP_CHK_MONOTONIC_EN
        fail_seen_d = fail_seen_q;
        nonmono_d   = nonmono_q;
`endif
        if (accept) begin
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
            off_d = trial_offset_i;
            // The first trial of a point fixes the point's slope indices
            if (!pt_act_q) begin
                pt_ck_d  = trial_ck_idx_i;
                pt_d_d   = trial_d_idx_i;
                pt_act_d = 1'b1;
            end else if (trial_ck_idx_i != pt_ck_q || trial_d_idx_i != pt_d_q) begin
                proto_d = 1'b1;
            end
            if (point_done_i) proto_d = 1'b1;
            if (!idx_ok(trial_ck_idx_i, trial_d_idx_i)) proto_d = 1'b1;
        end else if (state_q == ST_SETTLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (do_sample) begin
`ifdef SETUP_CHK_MONOTONIC_EN
            // A pass below a fail is reported, not used as the minimum
            if (q_sample_i) begin
                if (fail_seen_q) begin
                    nonmono_d = 1'b1;
                end else begin
                    best_d  = (off_q < best_q) ? off_q : best_q;
                    found_d = 1'b1;
                end
            end else begin
                fail_seen_d = 1'b1;
            end
`else
            if (q_sample_i) begin
                best_d  = (off_q < best_q) ? off_q : best_q;
                found_d = 1'b1;
            end
`endif
        end

        if (do_emit) begin
            best_d   = '1;
            found_d  = 1'b0;
            pt_act_d = 1'b0;
`ifdef SETUP_CHK_MONOTONIC_EN
            fail_seen_d = 1'b0;
            nonmono_d   = 1'b0;
`endif
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
    end

    // Datapath registers; best resets to all-ones so any pass lowers it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            off_q    <= '0;
            pt_ck_q  <= '0;
            pt_d_q   <= '0;
            pt_act_q <= 1'b0;
            best_q   <= '1;
            found_q  <= 1'b0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
`ifdef SETUP_CHK_MONOTONIC_EN
            fail_seen_q <= 1'b0;
            nonmono_q   <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            pt_ck_q  <= pt_ck_d;
            pt_d_q   <= pt_d_d;
            pt_act_q <= pt_act_d;
            best_q   <= best_d;
            found_q  <= found_d;
            ovf_q    <= ovf_d;
            proto_q  <= proto_d;
`ifdef SETUP_CHK_MONOTONIC_EN
            fail_seen_q <= fail_seen_d;
            nonmono_q   <= nonmono_d;
`endif
        end
    end

    // Result entry assembled from the point accumulators
    always_comb begin
        push_data        = '0;
        push_data.ck_idx = CHK_IDX_W'(pt_ck_q);
        push_data.d_idx  = CHK_IDX_W'(pt_d_q);
        push_data.offset = CHK_OFFSET_W'(best_q);
        push_data.found  = found_q;
`ifdef SETUP_CHK_MONOTONIC_EN
        push_data.nonmono = nonmono_q;
`else
        push_data.nonmono = 1'b0;
`endif
    end

    assign fifo_pop = res_ready_i & ~fifo_empty;

    setup_chk_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (do_emit),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign res_valid_o   = ~fifo_empty;
    assign res_ck_idx_o  = IDX_W'(head.ck_idx);
    assign res_d_idx_o   = IDX_W'(head.d_idx);
    assign res_offset_o  = OFFSET_W'(head.offset);
    assign res_found_o   = head.found;
    assign res_nonmono_o = head.nonmono;
    assign ovf_o         = ovf_q;
    assign proto_err_o   = proto_q;

endmodule
